// File: rtl/sopc_boot_loader.sv
// sopc_boot_loader
// Hardware program loader for the minimal OpenMIPS SOPC. It takes a framed
// byte stream (0xA5, count_hi, count_lo, 4*N payload bytes, optional checksum).
// It assembles big-endian 32-bit words and writes them to the instruction
// ROM write port. The CPU is held in reset until a complete frame is loaded.
//
// Build option: define BOOT_CSUM_EN to add the trailing checksum byte and the
// CSUM state. When it is undefined the frame ends with the last payload word.
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready.
// in_ready is 1 in every state once out of reset, so the loader never stalls
// the source. in_valid may be held high for back-to-back bytes.
//
// state_dbg exposes the FSM state encoding for checkers.
module sopc_boot_loader #(
    parameter int          ADDR_WIDTH = 17,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [2:0]            state_dbg
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    // Idle counter width; kept at least 1 bit so TIMEOUT of 0 or 1 still elaborates.
    localparam int             IW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0]  TO_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef BOOT_CSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            cnt_hi, cnt_hi_nxt;
    logic [15:0]           words_left, words_left_nxt;
    logic [1:0]            byte_idx, byte_idx_nxt;
    logic [23:0]           asm_q, asm_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [IW-1:0]         idle_cnt, idle_nxt;
`ifdef BOOT_CSUM_EN
    logic [7:0]            sum, sum_nxt;
`endif
    logic                  rom_we_nxt;
    logic [ADDR_WIDTH-1:0] rom_addr_nxt;
    logic [31:0]           rom_wdata_nxt;
    logic                  cpu_rst_nxt, load_done_nxt, load_err_nxt;
    logic                  accept, timed;

    assign accept    = in_valid & in_ready;
    assign timed     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA)
`ifdef BOOT_CSUM_EN
                       || (state == S_CSUM)
`endif
                       ;
    assign state_dbg = state;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_hi     <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            wr_addr    <= '0;
            idle_cnt   <= '0;
`ifdef BOOT_CSUM_EN
            sum        <= '0;
`endif
            in_ready   <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            cnt_hi     <= cnt_hi_nxt;
            words_left <= words_left_nxt;
            byte_idx   <= byte_idx_nxt;
            asm_q      <= asm_nxt;
            wr_addr    <= wr_addr_nxt;
            idle_cnt   <= idle_nxt;
`ifdef BOOT_CSUM_EN
            sum        <= sum_nxt;
`endif
            in_ready   <= 1'b1;
            rom_we     <= rom_we_nxt;
            rom_addr   <= rom_addr_nxt;
            rom_wdata  <= rom_wdata_nxt;
            cpu_rst    <= cpu_rst_nxt;
            load_done  <= load_done_nxt;
            load_err   <= load_err_nxt;
        end
    end

    // Next-state, datapath updates and output values
    always_comb begin
        state_nxt      = state;
        cnt_hi_nxt     = cnt_hi;
        words_left_nxt = words_left;
        byte_idx_nxt   = byte_idx;
        asm_nxt        = asm_q;
        wr_addr_nxt    = wr_addr;
        idle_nxt       = (timed && !accept) ? idle_cnt + IW'(1) : '0;
`ifdef BOOT_CSUM_EN
        sum_nxt        = sum;
`endif
        rom_we_nxt     = 1'b0;
        rom_addr_nxt   = rom_addr;
        rom_wdata_nxt  = rom_wdata;
        cpu_rst_nxt    = cpu_rst;
        load_done_nxt  = load_done;
        load_err_nxt   = load_err;

        case (state)
            // Waiting for a sync byte; everything else is dropped.
            S_IDLE, S_RUN, S_ERR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_nxt     = S_LEN_HI;
                    cpu_rst_nxt   = 1'b1;
                    load_done_nxt = 1'b0;
                    load_err_nxt  = 1'b0;
                    wr_addr_nxt   = '0;
`ifdef BOOT_CSUM_EN
                    sum_nxt       = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    cnt_hi_nxt = in_data;
                    state_nxt  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    words_left_nxt = {cnt_hi, in_data};
                    byte_idx_nxt   = '0;
                    if ({cnt_hi, in_data} == 16'd0) begin
`ifdef BOOT_CSUM_EN
                        state_nxt     = S_CSUM;
`else
                        state_nxt     = S_RUN;
                        cpu_rst_nxt   = 1'b0;
                        load_done_nxt = 1'b1;
`endif
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            // Payload: shift bytes in MSB first, write on every 4th byte.
            S_DATA: begin
                if (accept) begin
                    asm_nxt      = {asm_q[15:0], in_data};
                    byte_idx_nxt = byte_idx + 2'd1;
`ifdef BOOT_CSUM_EN
                    sum_nxt      = sum + in_data;
`endif
                    if (byte_idx == 2'd3) begin
                        rom_we_nxt     = 1'b1;
                        rom_wdata_nxt  = {asm_q, in_data};
                        rom_addr_nxt   = wr_addr;
                        wr_addr_nxt    = wr_addr + ADDR_WIDTH'(1);
                        words_left_nxt = words_left - 16'd1;
                        if (words_left == 16'd1) begin
`ifdef BOOT_CSUM_EN
                            state_nxt     = S_CSUM;
`else
                            state_nxt     = S_RUN;
                            cpu_rst_nxt   = 1'b0;
                            load_done_nxt = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef BOOT_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (in_data == sum) begin
                        state_nxt     = S_RUN;
                        cpu_rst_nxt   = 1'b0;
                        load_done_nxt = 1'b1;
                    end else begin
                        state_nxt    = S_ERR;
                        load_err_nxt = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        // A stalled frame aborts; words already written are left in memory.
        if (TIMEOUT != 0 && timed && !accept && idle_cnt == TO_LAST) begin
            state_nxt    = S_ERR;
            load_err_nxt = 1'b1;
        end
    end

endmodule
